fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 30 +++
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle: redirect requests and memory ready from the pipeline,
// PC-mux/enable/flush controls and status back to it.
interface fetch_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             br_res_ex;
   logic             trap_req;
   logic             mret_ex;
   logic             stall_id;
   logic             imem_ready;
   logic [1:0]       pc_sel;
   logic             pc_we;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             trap_ack;
   logic [CNT_W-1:0] redirect_cnt;
   logic             busy;

   // Pipeline side: raises requests, consumes controls.
   modport master (
      output br_res_ex, trap_req, mret_ex, stall_id, imem_ready,
      input  pc_sel, pc_we, if_id_flush, id_ex_flush, trap_ack, redirect_cnt, busy
   );

   // Controller side.
   modport slave (
      input  br_res_ex, trap_req, mret_ex, stall_id, imem_ready,
      output pc_sel, pc_we, if_id_flush, id_ex_flush, trap_ack, redirect_cnt, busy
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC mux select, PC load and pipeline flushes for a
// 5-stage core, with boot hold, pending redirect and one-cycle drain.
//
// state | meaning
// BOOT  | post-reset hold, fetch disabled for BOOT_CYCLES cycles
// RUN   | normal fetch, redirects committed when imem is ready
// PEND  | redirect waiting for imem_ready, target held in pend_sel
// DRAIN | one cycle after a redirect commit, IF/ID bubbled
module fetch_ctrl #(
   parameter int BOOT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   fetch_ctrl_if.slave bus
);
   typedef enum logic [1:0] {BOOT, RUN, PEND, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [3:0]       boot_cnt_q, boot_cnt_d;
   logic [1:0]       pend_sel_q, pend_sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]       req_code;
   logic [1:0]       pend_eff;
   logic [1:0]       pc_sel;
   logic             pc_we, if_flush, id_flush, ack;

   // Request priority encode: trap > mret > branch; 0 means no request.
   always_comb begin
      req_code = 2'd0;
      if (bus.trap_req)       req_code = 2'd2;
      else if (bus.mret_ex)   req_code = 2'd3;
      else if (bus.br_res_ex) req_code = 2'd1;
   end

   // A trap arriving while pending takes over the held redirect target.
   assign pend_eff = bus.trap_req ? 2'd2 : pend_sel_q;

   // State, boot timer, pending target and redirect counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         boot_cnt_q <= 4'(BOOT_CYCLES);
         pend_sel_q <= 2'd0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         pend_sel_q <= pend_sel_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state and output decode; reset forces the BOOT output values.
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      pend_sel_d = pend_sel_q;
      cnt_d      = cnt_q;
      pc_sel     = 2'd0;
      pc_we      = 1'b0;
      if_flush   = 1'b0;
      id_flush   = 1'b0;
      ack        = 1'b0;
      case (state_q)
         BOOT: begin
            if_flush = 1'b1;
            id_flush = 1'b1;
            if (boot_cnt_q <= 4'd1) state_d = RUN;
            else                    boot_cnt_d = boot_cnt_q - 4'd1;
         end
         RUN: begin
            if (req_code != 2'd0) begin
               pc_sel   = req_code;
               if_flush = 1'b1;
               id_flush = 1'b1;
               if (bus.imem_ready) begin
                  pc_we   = 1'b1;
                  cnt_d   = cnt_q + 1'b1;
                  ack     = (req_code == 2'd2);
                  state_d = DRAIN;
               end else begin
                  pend_sel_d = req_code;
                  state_d    = PEND;
               end
            end else begin
               pc_we    = bus.imem_ready & ~bus.stall_id;
               id_flush = bus.stall_id;
            end
         end
         PEND: begin
            pc_sel     = pend_eff;
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            pend_sel_d = pend_eff;
            if (bus.imem_ready) begin
               pc_we   = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               ack     = (pend_eff == 2'd2);
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            pc_we    = bus.imem_ready;
            if_flush = 1'b1;
            state_d  = RUN;
         end
         default: state_d = BOOT;
      endcase
      if (rst) begin
         pc_sel   = 2'd0;
         pc_we    = 1'b0;
         if_flush = 1'b1;
         id_flush = 1'b1;
         ack      = 1'b0;
      end
   end

   assign bus.pc_sel       = pc_sel;
   assign bus.pc_we        = pc_we;
   assign bus.if_id_flush  = if_flush;
   assign bus.id_ex_flush  = id_flush;
   assign bus.trap_ack     = ack;
   assign bus.redirect_cnt = cnt_q;
   assign bus.busy         = rst | (state_q != RUN);
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, then random traffic against
// a cycle-level reference model.
module tb_fetch_ctrl;
   localparam int BOOT = 2;
   localparam int CW   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.CNT_W(CW)) bus ();
   fetch_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      bit rst, br, trap, mret, stall, rdy;
      int sel; bit we, ifl, idl, ack, busy; int cnt;
   } vec_t;

   vec_t tbl[29];
   int   n_vec = 0;
   int   n_mis = 0;

   // reference model variables
   int boot_left, pend, cnt;
   bit drain;
   int e_sel; bit e_we, e_ifl, e_idl, e_ack, e_busy;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d (vector %0d)", nm, act, exp, n_vec);
      end
   endtask

   task automatic drive(input bit r, input bit br, input bit tr, input bit mr, input bit st, input bit rd);
      rst = r; bus.br_res_ex = br; bus.trap_req = tr; bus.mret_ex = mr;
      bus.stall_id = st; bus.imem_ready = rd;
   endtask

   task automatic compare(input int sel, input bit we, input bit ifl, input bit idl,
                          input bit ack, input bit busy, input int c);
      n_vec++;
      check("pc_sel", 32'(bus.pc_sel), 32'(sel));
      check("pc_we", 32'(bus.pc_we), 32'(we));
      check("if_id_flush", 32'(bus.if_id_flush), 32'(ifl));
      check("id_ex_flush", 32'(bus.id_ex_flush), 32'(idl));
      check("trap_ack", 32'(bus.trap_ack), 32'(ack));
      check("busy", 32'(bus.busy), 32'(busy));
      check("redirect_cnt", 32'(bus.redirect_cnt), 32'(c));
   endtask

   // Expected outputs for the current inputs and model status.
   task automatic model_eval();
      int code;
      e_sel = 0; e_we = 0; e_ifl = 0; e_idl = 0; e_ack = 0;
      e_busy = rst || boot_left > 0 || drain || pend >= 0;
      if (rst || boot_left > 0) begin
         e_ifl = 1; e_idl = 1;
      end else if (drain) begin
         e_we = bus.imem_ready; e_ifl = 1;
      end else if (pend >= 0) begin
         code = bus.trap_req ? 2 : pend;
         e_sel = code; e_we = bus.imem_ready; e_ifl = 1; e_idl = 1;
         e_ack = bus.imem_ready && code == 2;
      end else begin
         code = bus.trap_req ? 2 : bus.mret_ex ? 3 : bus.br_res_ex ? 1 : 0;
         if (code != 0) begin
            e_sel = code; e_we = bus.imem_ready; e_ifl = 1; e_idl = 1;
            e_ack = bus.imem_ready && code == 2;
         end else begin
            e_we = bus.imem_ready && !bus.stall_id; e_idl = bus.stall_id;
         end
      end
   endtask

   // Model status update at the clock edge.
   task automatic model_step();
      int code;
      if (rst) begin
         boot_left = BOOT; pend = -1; drain = 0; cnt = 0;
      end else if (boot_left > 0) begin
         boot_left--;
      end else if (drain) begin
         drain = 0;
      end else begin
         if (pend >= 0) code = bus.trap_req ? 2 : pend;
         else code = bus.trap_req ? 2 : bus.mret_ex ? 3 : bus.br_res_ex ? 1 : 0;
         if (code != 0) begin
            if (bus.imem_ready) begin
               cnt = (cnt + 1) % (1 << CW); pend = -1; drain = 1;
            end else pend = code;
         end
      end
   endtask

   initial begin
      bit trap_hold;
      int rst_left;
      //             rst br tr mr st rdy  sel we ifl idl ack busy cnt
      tbl[0]  = '{1, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 1, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 1, 0};
      tbl[2]  = '{0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 1, 0};
      tbl[3]  = '{0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 1, 0, 0, 0, 1,  1, 1, 1, 1, 0, 0, 0};
      tbl[5]  = '{0, 1, 0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 1};
      tbl[6]  = '{0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 1};
      tbl[7]  = '{0, 1, 1, 1, 0, 1,  2, 1, 1, 1, 1, 0, 1};
      tbl[8]  = '{0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 2};
      tbl[9]  = '{0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 0, 0, 2};
      tbl[10] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2};
      tbl[11] = '{0, 1, 0, 0, 1, 1,  1, 1, 1, 1, 0, 0, 2};
      tbl[12] = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 3};
      tbl[13] = '{0, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 3};
      tbl[14] = '{0, 0, 0, 0, 1, 0,  1, 0, 1, 1, 0, 1, 3};
      tbl[15] = '{0, 0, 1, 0, 0, 0,  2, 0, 1, 1, 0, 1, 3};
      tbl[16] = '{0, 0, 1, 0, 0, 0,  2, 0, 1, 1, 0, 1, 3};
      tbl[17] = '{0, 0, 1, 0, 0, 1,  2, 1, 1, 1, 1, 1, 3};
      tbl[18] = '{0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 4};
      tbl[19] = '{0, 0, 0, 1, 0, 1,  3, 1, 1, 1, 0, 0, 4};
      tbl[20] = '{0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 5};
      tbl[21] = '{0, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 5};
      tbl[22] = '{0, 0, 1, 0, 0, 0,  2, 0, 1, 1, 0, 1, 5};
      tbl[23] = '{1, 0, 1, 0, 0, 1,  0, 0, 1, 1, 0, 1, 5};
      tbl[24] = '{0, 0, 1, 0, 0, 1,  0, 0, 1, 1, 0, 1, 0};
      tbl[25] = '{0, 0, 1, 0, 0, 1,  0, 0, 1, 1, 0, 1, 0};
      tbl[26] = '{0, 0, 1, 0, 0, 1,  2, 1, 1, 1, 1, 0, 0};
      tbl[27] = '{0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 1};
      tbl[28] = '{0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 1};

      drive(1, 0, 0, 0, 0, 1);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 29; i++) begin
         drive(tbl[i].rst, tbl[i].br, tbl[i].trap, tbl[i].mret, tbl[i].stall, tbl[i].rdy);
         @(negedge clk);
         compare(tbl[i].sel, tbl[i].we, tbl[i].ifl, tbl[i].idl, tbl[i].ack, tbl[i].busy, tbl[i].cnt);
         @(posedge clk);
         #1;
      end

      // Table ends in RUN with one redirect counted since its reset.
      boot_left = 0; pend = -1; drain = 0; cnt = 1;
      trap_hold = 0; rst_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (rst_left == 0 && $urandom_range(0, 79) == 0) rst_left = $urandom_range(1, 2);
         if (!trap_hold && $urandom_range(0, 9) == 0) trap_hold = 1;
         drive(rst_left > 0, $urandom_range(0, 3) == 0, trap_hold,
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0);
         @(negedge clk);
         model_eval();
         compare(e_sel, e_we, e_ifl, e_idl, e_ack, e_busy, cnt);
         @(posedge clk);
         model_step();
         if (e_ack) trap_hold = 0;
         if (rst_left > 0) rst_left--;
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
